bfm_ahbl_slavemem: RTL and testbench
====================================

# bfm_ahbl_slavemem

Simulation AHB-Lite slave memory that sits directly downstream of the AHB-Lite BFM master and answers its transfers. Decodes one HSEL line, stores byte-addressable 32-bit words, inserts a programmable number of wait states, and optionally returns two-cycle ERROR responses for illegal accesses. Used as the default target in BFM regression benches.

## Interface
- AWIDTH, 10, word-address width; depth is 2^AWIDTH 32-bit words and the legal byte range is 0 to (4<<AWIDTH)-1.
- WAITSTATES, 0, wait cycles (0-15) inserted into every OKAY NONSEQ/SEQ data phase.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=halfword, 2=word.
- HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted, ignored.
- HWDATA  in  32  write data, valid in data phase.
- HREADYIN  in  1  bus HREADY; qualifies address phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

## Operation
- Accept: HSEL & HTRANS[1] & HREADYIN at a rising edge latches HADDR, HWRITE, HSIZE into the data-phase register. IDLE/BUSY, or HSEL=0, leaves no pending transfer; the following data phase is zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on accept, a legal transfer with WAITSTATES=0 stays IDLE with the data phase completing next cycle. A legal transfer with WAITSTATES>0 goes to WAIT and loads the counter with WAITSTATES-1. An illegal transfer goes to ERR1.
  - WAIT: HREADYOUT=0; counter decrements; at 0 returns to IDLE; the next cycle completes with HREADYOUT=1.
  - ERR1: HRESP=1, HREADYOUT=0 -> ERR2.
  - ERR2: HRESP=1, HREADYOUT=1; a new accept in this cycle is processed as from IDLE.
- Write commit: on the edge ending an OKAY write data phase (HREADYOUT=1), bytes are written using little-endian lane enables from latched HADDR[1:0] and HSIZE (byte: 1 lane; halfword: lanes {1:0} or {3:2}; word: all 4). An ERROR write commits nothing.
- Read: during an OKAY read data-phase cycle with HREADYOUT=1, HRDATA = mem[addr]. In all other cycles HRDATA=0. Full 32-bit word is driven regardless of HSIZE.
- Back-to-back write then read of the same address returns the new data, since the write commits on the same edge that accepts the read.
- Memory array is not reset; contents are X until written.
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, no pending transfer. An assertion mid-wait or mid-error aborts the transfer, and a pending write is discarded.

## Timing
- Zero-wait latency: address phase at edge N; data phase completes at edge N+1.
- With WAITSTATES=W: HREADYOUT is low for W cycles, and the transfer completes at edge N+1+W.
- Error: always exactly 2 data-phase cycles (ERR1, ERR2), independent of WAITSTATES.
- HREADYOUT/HRESP derive from registered state only; no combinational path from HADDR/HTRANS.

## Configuration
- BFM_AHBL_SLAVEMEM_ERRCHK_EN defined: a transfer is illegal if any of the following hold:
  - HSIZE>2;
  - misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]!=0);
  - HADDR >= 4<<AWIDTH.
  Illegal transfers take the ERR1/ERR2 path.
- Undefined: no transfer is illegal and HRESP is tied 0. The address wraps modulo 4<<AWIDTH. Misaligned low bits are forced to alignment (halfword clears bit 0, word clears bits 1:0). HSIZE>2 is treated as a word.

## Test plan
- Reset held 3 cycles, then released -> HREADYOUT=1, HRESP=0, HRDATA=0 on every cycle.
- WAITSTATES=0: word write 0xDEADBEEF to 0x10, then back-to-back read of 0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HREADYOUT never low.
- Byte write 0x5A to 0x13 over word 0x11223344 at 0x10 -> read of 0x10 returns 0x5A223344. Halfword write 0xABCD to 0x10 -> 0x5A22ABCD.
- WAITSTATES=3: a read shows HREADYOUT low for exactly 3 cycles, then data. Reset asserted during the 2nd wait cycle -> HREADYOUT=1 on the next cycle and the pending write is absent on readback.
- With ERRCHK_EN, AWIDTH=10: write to 0x1000 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, and no memory change. Word access to 0x2 -> same two-cycle ERROR.
- Without ERRCHK_EN: write 0x77 to 0x1004 -> read of 0x4 returns 0x77 in lane 0, and HRESP stays 0 throughout.

Source files
------------

// File: rtl/bfm_ahbl_slavemem.sv
// AHB-Lite slave memory for BFM benches: byte-lane writes, programmable wait states.
// Define BFM_AHBL_SLAVEMEM_ERRCHK_EN to answer illegal accesses with a two-cycle ERROR.
module bfm_ahbl_slavemem #(
   parameter int AWIDTH     = 10,
   parameter int WAITSTATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADYIN,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int         DEPTH     = 1 << AWIDTH;
   localparam logic [3:0] WAIT_LOAD = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t              state;
   logic [3:0]          wait_cnt;
   logic                ready_q;
   logic                resp_q;
   logic                dp_valid;
   logic                dp_write;
   logic [AWIDTH-1:0]   dp_addr;
   logic [3:0]          dp_lanes;
   logic [31:0]         mem [DEPTH];

   logic                accept;
   logic                illegal;
   logic                write_en;
   logic [1:0]          eff_size;
   logic [3:0]          lanes;

   // Only a cycle where this slave is itself ready can start a new data phase.
   assign accept = HSEL & HTRANS[1] & HREADYIN & ready_q;

   always_comb begin
      eff_size = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];
      unique case (eff_size)
         2'd0:    lanes = 4'b0001 << HADDR[1:0];
         2'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

`ifdef BFM_AHBL_SLAVEMEM_ERRCHK_EN
   assign illegal = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                  | ((HADDR >> (AWIDTH + 2)) != 32'd0);
`else
   assign illegal = 1'b0;
`endif

   // dp_valid marks a legal data phase; error data phases never commit or drive data.
   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         ready_q  <= 1'b1;
         resp_q   <= 1'b0;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         dp_lanes <= 4'd0;
      end else begin
         unique case (state)
            ST_IDLE, ST_ERR2: begin
               dp_valid <= accept & ~illegal;
               if (accept) begin
                  dp_write <= HWRITE;
                  dp_addr  <= HADDR[AWIDTH+1:2];
                  dp_lanes <= lanes;
               end
               if (accept && illegal) begin
                  state   <= ST_ERR1;
                  ready_q <= 1'b0;
                  resp_q  <= 1'b1;
               end else if (accept && (WAITSTATES > 0)) begin
                  state    <= ST_WAIT;
                  wait_cnt <= WAIT_LOAD;
                  ready_q  <= 1'b0;
                  resp_q   <= 1'b0;
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state   <= ST_ERR2;
               ready_q <= 1'b1;
               resp_q  <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               resp_q  <= 1'b0;
            end
         endcase
      end
   end

   // A write lands on the edge that ends its ready data phase, unless reset is asserted then.
   assign write_en = (state == ST_IDLE) & dp_valid & dp_write & HRESETN;

   // NOTE: the storage array has no reset branch; contents stay undefined until written.
   always_ff @(posedge HCLK) begin
      if (write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (dp_lanes[b]) mem[dp_addr][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HRDATA    = ((state == ST_IDLE) && dp_valid && !dp_write) ? mem[dp_addr] : 32'd0;
   assign HREADYOUT = ready_q;

`ifdef BFM_AHBL_SLAVEMEM_ERRCHK_EN
   assign HRESP = resp_q;
`else
   assign HRESP = 1'b0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR, HSIZE, resp_q};

endmodule

// File: tb/tb_bfm_ahbl_slavemem.sv
// Directed bench for bfm_ahbl_slavemem: one zero-wait and one three-wait instance.
// Error-path sequences follow BFM_AHBL_SLAVEMEM_ERRCHK_EN; otherwise wrap/alignment is exercised.
module tb_bfm_ahbl_slavemem;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NSEQ = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;
   localparam logic [2:0] SZ_B   = 3'd0;
   localparam logic [2:0] SZ_H   = 3'd1;
   localparam logic [2:0] SZ_W   = 3'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel0, sel1;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, resp0, resp1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bfm_ahbl_slavemem #(.AWIDTH(10), .WAITSTATES(0)) u_ws0 (
      .HCLK(clk), .HRESETN(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd3), .HMASTLOCK(1'b0),
      .HWDATA(hwdata), .HREADYIN(ready0), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
   );

   bfm_ahbl_slavemem #(.AWIDTH(10), .WAITSTATES(3)) u_ws3 (
      .HCLK(clk), .HRESETN(rst_n), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd3), .HMASTLOCK(1'b0),
      .HWDATA(hwdata), .HREADYIN(ready1), .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rst_n;
      logic        exp_ready;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   function automatic vec_t v(input logic s, input logic [1:0] t, input logic w,
                              input logic [2:0] z, input logic [31:0] a, input logic [31:0] wd,
                              input logic rn, input logic er, input logic [31:0] ed);
      vec_t r;
      r = '{sel: s, trans: t, write: w, size: z, addr: a, wdata: wd,
            rst_n: rn, exp_ready: er, exp_rdata: ed};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One bus cycle: drive address phase / write data at the falling edge, then check
   // the data-phase outputs of the selected instance for this same cycle.
   task automatic step(input logic d, input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] z, input logic [31:0] a, input logic [31:0] wd,
                       input logic rn, input logic er, input logic ep, input logic [31:0] ed,
                       input string name);
      @(negedge clk);
      sel0   = s & ~d;
      sel1   = s & d;
      htrans = t;
      hwrite = w;
      hsize  = z;
      haddr  = a;
      hwdata = wd;
      rst_n  = rn;
      #1;
      check({name, " ready"}, {31'd0, d ? ready1 : ready0}, {31'd0, er});
      check({name, " resp"},  {31'd0, d ? resp1 : resp0},   {31'd0, ep});
      check({name, " rdata"}, d ? rdata1 : rdata0, ed);
   endtask

   task automatic idle(input logic d, input logic [31:0] wd, input logic er, input logic ep,
                       input logic [31:0] ed, input string name);
      step(d, 1'b0, T_IDLE, 1'b0, SZ_W, 32'd0, wd, 1'b1, er, ep, ed, name);
   endtask

   initial begin
      rst_n  = 1'b0;
      sel0   = 1'b0;
      sel1   = 1'b0;
      htrans = T_IDLE;
      hwrite = 1'b0;
      hsize  = SZ_W;
      haddr  = 32'd0;
      hwdata = 32'd0;

      vecs[0]  = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        0, 1, 32'h0);
      vecs[1]  = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        0, 1, 32'h0);
      vecs[2]  = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        0, 1, 32'h0);
      vecs[3]  = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        1, 1, 32'h0);
      vecs[4]  = v(1, T_NSEQ, 1, SZ_W, 32'h10, 32'h0,        1, 1, 32'h0);
      vecs[5]  = v(1, T_NSEQ, 0, SZ_W, 32'h10, 32'hDEADBEEF, 1, 1, 32'h0);
      vecs[6]  = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        1, 1, 32'hDEADBEEF);
      vecs[7]  = v(1, T_NSEQ, 1, SZ_W, 32'h10, 32'h0,        1, 1, 32'h0);
      vecs[8]  = v(1, T_NSEQ, 1, SZ_B, 32'h13, 32'h11223344, 1, 1, 32'h0);
      vecs[9]  = v(1, T_NSEQ, 0, SZ_W, 32'h10, 32'h5A000000, 1, 1, 32'h0);
      vecs[10] = v(1, T_NSEQ, 1, SZ_H, 32'h10, 32'h0,        1, 1, 32'h5A223344);
      vecs[11] = v(1, T_NSEQ, 0, SZ_W, 32'h10, 32'h0000ABCD, 1, 1, 32'h0);
      vecs[12] = v(1, T_NSEQ, 1, SZ_H, 32'h12, 32'h0,        1, 1, 32'h5A22ABCD);
      vecs[13] = v(1, T_NSEQ, 0, SZ_W, 32'h10, 32'h99880000, 1, 1, 32'h0);
      vecs[14] = v(1, T_BUSY, 0, SZ_W, 32'h10, 32'h0,        1, 1, 32'h9988ABCD);
      vecs[15] = v(0, T_NSEQ, 0, SZ_W, 32'h10, 32'h0,        1, 1, 32'h0);
      vecs[16] = v(1, T_SEQ,  0, SZ_B, 32'h11, 32'h0,        1, 1, 32'h0);
      vecs[17] = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        1, 1, 32'h9988ABCD);
      vecs[18] = v(0, T_IDLE, 0, SZ_W, 32'h00, 32'h0,        1, 1, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         step(1'b0, vecs[i].sel, vecs[i].trans, vecs[i].write, vecs[i].size, vecs[i].addr,
              vecs[i].wdata, vecs[i].rst_n, vecs[i].exp_ready, 1'b0, vecs[i].exp_rdata,
              $sformatf("vec%0d", i));
      end

      // Three wait states: write, then read, each with exactly three not-ready cycles.
      step(1, 1, T_NSEQ, 1, SZ_W, 32'h20, 32'h0, 1, 1, 0, 32'h0, "ws3 wr addr");
      for (int i = 0; i < 3; i++) idle(1, 32'hCAFEF00D, 0, 0, 32'h0, $sformatf("ws3 wr wait%0d", i));
      step(1, 1, T_NSEQ, 0, SZ_W, 32'h20, 32'hCAFEF00D, 1, 1, 0, 32'h0, "ws3 wr done");
      for (int i = 0; i < 3; i++) idle(1, 32'h0, 0, 0, 32'h0, $sformatf("ws3 rd wait%0d", i));
      idle(1, 32'h0, 1, 0, 32'hCAFEF00D, "ws3 rd data");
      idle(1, 32'h0, 1, 0, 32'h0, "ws3 rd after");

      // Reset during the second wait cycle of a write discards it.
      step(1, 1, T_NSEQ, 1, SZ_W, 32'h20, 32'h0, 1, 1, 0, 32'h0, "rstw addr");
      idle(1, 32'h12345678, 0, 0, 32'h0, "rstw wait1");
      step(1, 0, T_IDLE, 0, SZ_W, 32'h0, 32'h12345678, 0, 0, 0, 32'h0, "rstw wait2");
      idle(1, 32'h0, 1, 0, 32'h0, "rstw released");
      step(1, 1, T_NSEQ, 0, SZ_W, 32'h20, 32'h0, 1, 1, 0, 32'h0, "rstw rd addr");
      for (int i = 0; i < 3; i++) idle(1, 32'h0, 0, 0, 32'h0, $sformatf("rstw rd wait%0d", i));
      idle(1, 32'h0, 1, 0, 32'hCAFEF00D, "rstw rd data");

`ifdef BFM_AHBL_SLAVEMEM_ERRCHK_EN
      // Out-of-range write errors and leaves word 0 intact; misaligned word read errors.
      step(0, 1, T_NSEQ, 1, SZ_W, 32'h0,    32'h0,        1, 1, 0, 32'h0, "ec wr0 addr");
      step(0, 1, T_NSEQ, 1, SZ_W, 32'h1000, 32'h01010101, 1, 1, 0, 32'h0, "ec oob addr");
      idle(0, 32'hFFFFFFFF, 0, 1, 32'h0, "ec oob err1");
      step(0, 1, T_NSEQ, 0, SZ_W, 32'h0,    32'hFFFFFFFF, 1, 1, 1, 32'h0, "ec oob err2");
      step(0, 1, T_NSEQ, 0, SZ_W, 32'h2,    32'h0,        1, 1, 0, 32'h01010101, "ec rd0 data");
      idle(0, 32'h0, 0, 1, 32'h0, "ec mis err1");
      idle(0, 32'h0, 1, 1, 32'h0, "ec mis err2");
      idle(0, 32'h0, 1, 0, 32'h0, "ec mis after");
      // Error length does not depend on wait states.
      step(1, 1, T_NSEQ, 1, SZ_W, 32'h1000, 32'h0, 1, 1, 0, 32'h0, "ec ws3 addr");
      idle(1, 32'h0, 0, 1, 32'h0, "ec ws3 err1");
      idle(1, 32'h0, 1, 1, 32'h0, "ec ws3 err2");
      idle(1, 32'h0, 1, 0, 32'h0, "ec ws3 after");
`else
      // Address wraps, low bits are aligned, and HSIZE>2 behaves as a word.
      step(0, 1, T_NSEQ, 1, SZ_W,  32'h1004, 32'h0,        1, 1, 0, 32'h0, "wrap wr addr");
      step(0, 1, T_NSEQ, 0, SZ_W,  32'h4,    32'h00000077, 1, 1, 0, 32'h0, "wrap rd addr");
      step(0, 1, T_NSEQ, 1, SZ_W,  32'h1007, 32'h0,        1, 1, 0, 32'h00000077, "wrap rd data");
      step(0, 1, T_NSEQ, 1, SZ_H,  32'h5,    32'hA5A5A5A5, 1, 1, 0, 32'h0, "align word data");
      step(0, 1, T_NSEQ, 0, SZ_W,  32'h4,    32'h0000BEEF, 1, 1, 0, 32'h0, "align half data");
      step(0, 1, T_NSEQ, 1, 3'd3,  32'h8,    32'h0,        1, 1, 0, 32'hA5A5BEEF, "align rd data");
      step(0, 1, T_NSEQ, 0, SZ_W,  32'h8,    32'h13572468, 1, 1, 0, 32'h0, "size3 wr data");
      idle(0, 32'h0, 1, 0, 32'h13572468, "size3 rd data");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
